// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the DAC sequencer
//
// Purpose: FSM state encoding, sequencer step field layout, default sample
//          width, and a helper that extracts one sequencer step.
// Ports:   none (package).

package dac_pkg;

   localparam int DW_DEFAULT = 12;

   // Sequencer program: 8 steps of 5 bits each, step i = seq[5i+4:5i].
   localparam int SEQ_STEPS    = 8;
   localparam int SEQ_STEP_W   = 5;
   localparam int SEQ_W        = SEQ_STEPS * SEQ_STEP_W;
   localparam int SEQ_CH_LSB   = 0;
   localparam int SEQ_CH_W     = 3;
   localparam int SEQ_SKIP_BIT = 3;
   localparam int SEQ_END_BIT  = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } dac_state_t;

   function automatic logic [SEQ_STEP_W-1:0] seq_step(input logic [SEQ_W-1:0] seq,
                                                      input logic [2:0]       idx);
      return seq[int'(idx)*SEQ_STEP_W +: SEQ_STEP_W];
   endfunction

endpackage

// File: rtl/dac_seq_ctrl_if.sv
// rtl/dac_seq_ctrl_if.sv - sample push port and DAC output bus
//
// Purpose: groups the FIFO push handshake and the DAC-facing output bus.
// Signals: wr/w_data   sample push into the controller FIFO
//          dac_data    registered DAC code
//          dac_load    one-clk load strobe
//          ch_sel_out  registered channel select
//          eoc         one-clk end-of-settle pulse
// Modports: master = controller side, slave = software/DAC side.

interface dac_seq_ctrl_if
   import dac_pkg::*;
#(
   parameter int DW = DW_DEFAULT
);
   logic          wr;
   logic [DW-1:0] w_data;
   logic [DW-1:0] dac_data;
   logic          dac_load;
   logic [2:0]    ch_sel_out;
   logic          eoc;

   modport master (
      input  wr, w_data,
      output dac_data, dac_load, ch_sel_out, eoc
   );

   modport slave (
      output wr, w_data,
      input  dac_data, dac_load, ch_sel_out, eoc
   );
endinterface

// File: rtl/dac_fifo.sv
// rtl/dac_fifo.sv - synchronous show-ahead FIFO with level output
//
// Purpose: sample buffer between software pushes and the paced DAC FSM.
// Ports:   clk, rst       clock, synchronous active-high reset (flushes)
//          wr, w_data     push; dropped while full, even with a pop
//          rd             pop; ignored while empty
//          r_data         head of FIFO (valid while not empty)
//          full, empty    status flags
//          level          number of stored words (0 .. 2**AW)

module dac_fifo #(
   parameter int DW = 12,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic [DW-1:0] w_data,
   input  logic          rd,
   output logic [DW-1:0] r_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Full is judged before any same-cycle pop, so a push at full is lost.
   assign push = wr && !full;
   assign pop  = rd && !empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      level <= level + (AW+1)'(1);
         else if (pop && !push) level <= level - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= w_data;
   end

   assign r_data = mem[rd_ptr];
   assign full   = (level == (AW+1)'(DEPTH));
   assign empty  = (level == '0);

endmodule

// File: rtl/dac_seq_ctrl.sv
// rtl/dac_seq_ctrl.sv - paced DAC sample sequencer with channel steering
//
// Purpose: pops one sample per update slot from the input FIFO, drives it on
//          the DAC bus with a load strobe, holds for a settle time and then
//          pulses eoc. An optional 8-step sequencer picks the channel.
// Ports:   clk, rst        clock, synchronous active-high reset
//          en              block enable; dropping it aborts to IDLE
//          clkdiv          tick every clkdiv+1 clocks
//          update_div      slot every update_div+1 ticks
//          settle_width    settle hold in ticks (w+1 ticks)
//          ch_sel_in       channel when the sequencer is off
//          seq_en, seq     sequencer enable and 8x5-bit program
//          fifo_threshold  fifo_below asserts when level < threshold
//          err_clr         clears underrun/late (a same-cycle set wins)
//          bus             push port and DAC output bus (master side)
//          busy            FSM not idle
//          fifo_full, fifo_empty, fifo_below   FIFO status
//          underrun, late  sticky error flags

module dac_seq_ctrl
   import dac_pkg::*;
#(
   parameter int CLKDIV_WIDTH = 8,
   parameter int FIFO_AW      = 4,
   parameter int DW           = DW_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [CLKDIV_WIDTH-1:0] clkdiv,
   input  logic [CLKDIV_WIDTH-1:0] update_div,
   input  logic [3:0]              settle_width,
   input  logic [2:0]              ch_sel_in,
   input  logic                    seq_en,
   input  logic [SEQ_W-1:0]        seq,
   input  logic [FIFO_AW-1:0]      fifo_threshold,
   input  logic                    err_clr,
   dac_seq_ctrl_if.master          bus,
   output logic                    busy,
   output logic                    fifo_full,
   output logic                    fifo_empty,
   output logic                    fifo_below,
   output logic                    underrun,
   output logic                    late
);
   localparam int CDW = CLKDIV_WIDTH;

   // Tick and slot dividers. Both counters sit at 0 while disabled so that
   // re-enabling always starts a fresh slot period.
   logic [CDW-1:0] div_cnt;
   logic [CDW-1:0] slot_cnt;
   logic           tick;
   logic           slot;

   assign tick = en && (div_cnt == clkdiv);
   assign slot = tick && (slot_cnt == update_div);

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         div_cnt  <= '0;
         slot_cnt <= '0;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + CDW'(1);
         if (slot)      slot_cnt <= '0;
         else if (tick) slot_cnt <= slot_cnt + CDW'(1);
      end
   end

   // FIFO
   logic [DW-1:0]    r_data;
   logic [FIFO_AW:0] level;
   logic             pop;

   dac_fifo #(
      .DW (DW),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr     (bus.wr),
      .w_data (bus.w_data),
      .rd     (pop),
      .r_data (r_data),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (level)
   );

   assign fifo_below = (level < {1'b0, fifo_threshold});

   // Sequencer step decode. The skip bit only has meaning with the
   // sequencer on; otherwise every slot is a real update.
   logic [2:0]            seq_ctr;
   logic [SEQ_STEP_W-1:0] step;
   logic                  step_skip;
   logic [2:0]            step_ch;
   logic [2:0]            seq_next;

   assign step      = seq_step(seq, seq_ctr);
   assign step_skip = seq_en && step[SEQ_SKIP_BIT];
   assign step_ch   = step[SEQ_CH_LSB +: SEQ_CH_W];
   assign seq_next  = step[SEQ_END_BIT] ? 3'd0 : seq_ctr + 3'd1;

   // FSM
   dac_state_t state;
   dac_state_t state_next;
   logic [3:0] settle_cnt;
   logic       latch;
   logic       seq_adv;
   logic       under_set;
   logic       late_set;
   logic       settle_clr;
   logic       settle_inc;

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      latch      = 1'b0;
      seq_adv    = 1'b0;
      under_set  = 1'b0;
      settle_clr = 1'b0;
      settle_inc = 1'b0;
      // A slot can only be accepted from IDLE; anywhere else it is lost.
      late_set   = slot && (state != ST_IDLE);

      if (!en) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (slot) begin
                  if (step_skip) begin
                     seq_adv = 1'b1;
                  end else if (fifo_empty) begin
                     under_set = 1'b1;
                     seq_adv   = 1'b1;
                  end else begin
                     state_next = ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               pop        = 1'b1;
               latch      = 1'b1;
               state_next = ST_LOAD;
            end
            ST_LOAD: begin
               settle_clr = 1'b1;
               state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (tick) begin
                  if (settle_cnt == settle_width) state_next = ST_DONE;
                  else                            settle_inc = 1'b1;
               end
            end
            ST_DONE: begin
               seq_adv    = 1'b1;
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Strobes are registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         busy         <= 1'b0;
         bus.dac_load <= 1'b0;
         bus.eoc      <= 1'b0;
      end else begin
         state        <= state_next;
         busy         <= (state_next != ST_IDLE);
         bus.dac_load <= (state_next == ST_LOAD);
         bus.eoc      <= (state_next == ST_DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
      end else if (settle_clr) begin
         settle_cnt <= '0;
      end else if (settle_inc) begin
         settle_cnt <= settle_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !seq_en) begin
         seq_ctr <= '0;
      end else if (seq_adv) begin
         seq_ctr <= seq_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.dac_data   <= '0;
         bus.ch_sel_out <= '0;
      end else if (latch) begin
         bus.dac_data   <= r_data;
         bus.ch_sel_out <= seq_en ? step_ch : ch_sel_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         underrun <= 1'b0;
         late     <= 1'b0;
      end else begin
         if (under_set)    underrun <= 1'b1;
         else if (err_clr) underrun <= 1'b0;
         if (late_set)     late <= 1'b1;
         else if (err_clr) late <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// tb/tb_dac_seq_ctrl.sv - bench for dac_seq_ctrl

module tb_dac_seq_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [7:0]  clkdiv = '0;
   logic [7:0]  update_div = '0;
   logic [3:0]  settle_width = '0;
   logic [2:0]  ch_sel_in = '0;
   logic        seq_en = 1'b0;
   logic [39:0] seq = '0;
   logic [3:0]  fifo_threshold = '0;
   logic        err_clr = 1'b0;
   logic        busy, fifo_full, fifo_empty, fifo_below, underrun, late;

   dac_seq_ctrl_if #(.DW(12)) bus ();

   dac_seq_ctrl #(.CLKDIV_WIDTH(8), .FIFO_AW(4), .DW(12)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .clkdiv         (clkdiv),
      .update_div     (update_div),
      .settle_width   (settle_width),
      .ch_sel_in      (ch_sel_in),
      .seq_en         (seq_en),
      .seq            (seq),
      .fifo_threshold (fifo_threshold),
      .err_clr        (err_clr),
      .bus            (bus),
      .busy           (busy),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .fifo_below     (fifo_below),
      .underrun       (underrun),
      .late           (late)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: actual %0h required %0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Tick/slot from elapsed enabled cycles; an accepted update is tracked by
   // its age in clocks and the number of settle ticks seen.
   int          m_q[$];
   int          m_en_cyc, m_tk, m_seq, m_age, m_stl;
   bit          m_act;
   logic [11:0] e_data;
   logic [2:0]  e_ch;
   bit          e_load, e_eoc, e_busy, e_under, e_late;

   always @(posedge clk) begin
      bit tick, slot, push, pop, adv, uset, lset, done_now;
      logic [4:0] stp;
      cyc++;
      if (rst) begin
         m_q.delete();
         m_en_cyc = 0; m_tk = 0; m_seq = 0; m_act = 0; m_age = 0; m_stl = 0;
         e_data = '0; e_ch = '0; e_load = 0; e_eoc = 0; e_busy = 0; e_under = 0; e_late = 0;
      end else begin
         tick = en && ((m_en_cyc % (int'(clkdiv) + 1)) == int'(clkdiv));
         slot = tick && ((m_tk % (int'(update_div) + 1)) == int'(update_div));
         stp  = 5'(seq >> (5 * m_seq));
         push = bus.wr && (m_q.size() < 16);
         pop = 0; adv = 0; uset = 0; lset = 0; done_now = 0;
         if (!en) begin
            m_act = 0;
         end else if (!m_act) begin
            if (slot) begin
               if (seq_en && stp[3]) adv = 1;
               else if (m_q.size() == 0) begin uset = 1; adv = 1; end
               else begin m_act = 1; m_age = 1; end
            end
         end else begin
            lset = slot;
            if (e_eoc) begin
               m_act = 0; adv = 1;
            end else if (m_age == 1) begin
               pop = 1;
               e_data = 12'(m_q[0]);
               e_ch = seq_en ? stp[2:0] : ch_sel_in;
            end else if (m_age == 2) begin
               m_stl = 0;
            end else if (tick) begin
               if (m_stl == int'(settle_width)) done_now = 1;
               else m_stl++;
            end
            m_age++;
         end
         if (!seq_en) m_seq = 0;
         else if (adv) m_seq = stp[4] ? 0 : (m_seq + 1) % 8;
         if (pop) void'(m_q.pop_front());
         if (push) m_q.push_back(int'(bus.w_data));
         if (uset) e_under = 1; else if (err_clr) e_under = 0;
         if (lset) e_late = 1;  else if (err_clr) e_late = 0;
         e_eoc  = done_now;
         e_busy = m_act;
         e_load = m_act && (m_age == 2);
         if (en) begin
            if (tick) m_tk++;
            m_en_cyc++;
         end else begin
            m_en_cyc = 0; m_tk = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_on = 0;
   int ld_data[$];
   int ld_ch[$];
   int n_eoc = 0;
   int n_late_seen = 0;

   always @(negedge clk) begin
      logic [31:0] exp_v, act_v;
      if (chk_on) begin
         exp_v = {9'd0, e_data, e_ch, e_load, e_busy, e_eoc,
                  m_q.size() == 16, m_q.size() == 0, m_q.size() < int'(fifo_threshold),
                  e_under, e_late};
         act_v = {9'd0, bus.dac_data, bus.ch_sel_out, bus.dac_load, busy, bus.eoc,
                  fifo_full, fifo_empty, fifo_below, underrun, late};
         chk("outputs", act_v, exp_v);
         if (bus.dac_load) begin
            ld_data.push_back(int'(bus.dac_data));
            ld_ch.push_back(int'(bus.ch_sel_out));
         end
         if (bus.eoc) n_eoc++;
         if (late) n_late_seen++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] d);
      bus.wr = 1'b1; bus.w_data = d;
      step(1);
      bus.wr = 1'b0;
   endtask

   task automatic clear_logs();
      ld_data.delete(); ld_ch.delete(); n_eoc = 0; n_late_seen = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; step(2); rst = 1'b0;
   endtask

   function automatic int ld_d(input int i);
      if (i < ld_data.size()) return ld_data[i];
      return -1;
   endfunction

   function automatic int ld_c(input int i);
      if (i < ld_ch.size()) return ld_ch[i];
      return -1;
   endfunction

   task automatic wait_load(input string nm);
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (bus.dac_load) begin found = 1; break; end
      end
      chk(nm, 32'(found), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      bus.wr = 1'b0; bus.w_data = '0;
      step(2);
      chk_on = 1;
      rst = 1'b0;
      // reset state
      chk("rst_dac_data", 32'(bus.dac_data), 32'h0);
      chk("rst_ch", 32'(bus.ch_sel_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_load_eoc", {bus.dac_load, bus.eoc}, 32'h0);
      chk("rst_flags", {underrun, late}, 32'h0);
      chk("rst_empty", 32'(fifo_empty), 32'h1);

      // 1: basic paced loads then underrun
      clkdiv = 8'd1; update_div = 8'd3; settle_width = 4'd2; ch_sel_in = 3'd2;
      push(12'h123); push(12'h456);
      clear_logs();
      en = 1'b1; step(64);
      chk("t1_nloads", ld_data.size(), 32'd2);
      chk("t1_data0", ld_d(0), 32'h123);
      chk("t1_data1", ld_d(1), 32'h456);
      chk("t1_ch0", ld_c(0), 32'd2);
      chk("t1_neoc", n_eoc, 32'd2);
      chk("t1_underrun", 32'(underrun), 32'd1);
      chk("t1_model_under", 32'(e_under), 32'd1);
      en = 1'b0; err_clr = 1'b1; step(1); err_clr = 1'b0;
      chk("t1_errclr", {underrun, late}, 32'h0);

      // 2: sequencer channels, skip step, end wrap
      do_reset();
      clkdiv = 8'd1; update_div = 8'd3; settle_width = 4'd0;
      seq_en = 1'b1; seq = '0; seq[14:0] = {5'b10101, 5'b01000, 5'b00011};
      push(12'hA01); push(12'hA02); push(12'hA03);
      clear_logs();
      en = 1'b1; step(40);
      chk("t2_nloads", ld_data.size(), 32'd3);
      chk("t2_ch0", ld_c(0), 32'd3);
      chk("t2_ch1", ld_c(1), 32'd5);
      chk("t2_ch2_wrap", ld_c(2), 32'd3);
      chk("t2_data1", ld_d(1), 32'hA02);
      chk("t2_data2", ld_d(2), 32'hA03);
      chk("t2_no_underrun", 32'(underrun), 32'd0);
      en = 1'b0; seq_en = 1'b0; seq = '0;

      // 3: late slots, err_clr and set-beats-clear
      do_reset();
      clkdiv = 8'd0; update_div = 8'd2; settle_width = 4'd15;
      push(12'hB01); push(12'hB02);
      clear_logs();
      en = 1'b1; step(20);
      chk("t3_nloads", ld_data.size(), 32'd1);
      chk("t3_late", 32'(late), 32'd1);
      chk("t3_not_empty", 32'(fifo_empty), 32'd0);
      en = 1'b0; step(1);
      err_clr = 1'b1; step(1); err_clr = 1'b0;
      chk("t3_late_clr", 32'(late), 32'd0);
      n_late_seen = 0;
      err_clr = 1'b1; en = 1'b1; step(25);
      err_clr = 1'b0;
      chk("t3_set_wins", 32'(n_late_seen != 0), 32'd1);
      en = 1'b0;

      // 4: overflow and threshold
      do_reset();
      fifo_threshold = 4'd4;
      for (int i = 0; i < 3; i++) push(12'(12'h100 + i));
      chk("t4_below_l3", 32'(fifo_below), 32'd1);
      push(12'h103);
      chk("t4_below_l4", 32'(fifo_below), 32'd0);
      for (int i = 4; i < 17; i++) push(12'(12'h100 + i));
      chk("t4_full", 32'(fifo_full), 32'd1);
      clear_logs();
      clkdiv = 8'd0; update_div = 8'd0; settle_width = 4'd0;
      en = 1'b1; step(100);
      chk("t4_nloads", ld_data.size(), 32'd16);
      chk("t4_last", ld_d(15), 32'h10F);
      chk("t4_empty", 32'(fifo_empty), 32'd1);
      en = 1'b0; fifo_threshold = 4'd0;

      // 5: reset during settle
      do_reset();
      clkdiv = 8'd1; update_div = 8'd1; settle_width = 4'd15;
      for (int i = 0; i < 4; i++) push(12'(12'hC01 + i));
      clear_logs();
      en = 1'b1;
      wait_load("t5_wait_load");
      step(3);
      chk("t5_busy_settle", 32'(busy), 32'd1);
      rst = 1'b1; step(1);
      chk("t5_rst_data", 32'(bus.dac_data), 32'h0);
      chk("t5_rst_state", {busy, bus.eoc, bus.dac_load, underrun, late}, 32'h0);
      chk("t5_rst_empty", 32'(fifo_empty), 32'd1);
      rst = 1'b0; en = 1'b0; step(2);
      chk("t5_no_eoc", n_eoc, 32'd0);

      // 6: enable dropped during settle, resume at next slot
      push(12'hD01); push(12'hD02);
      clear_logs();
      en = 1'b1;
      wait_load("t6_wait_load1");
      step(4);
      en = 1'b0; step(1);
      chk("t6_busy_off", 32'(busy), 32'd0);
      chk("t6_data_held", 32'(bus.dac_data), 32'hD01);
      step(5);
      chk("t6_no_eoc", n_eoc, 32'd0);
      en = 1'b1;
      wait_load("t6_wait_load2");
      chk("t6_resume_data", 32'(bus.dac_data), 32'hD02);
      step(40);
      chk("t6_eoc", n_eoc, 32'd1);
      en = 1'b0; step(1);

      // random traffic against the model
      for (int r = 0; r < 6; r++) begin
         en = 1'b0; step(1);
         clkdiv = 8'($urandom_range(0, 2));
         update_div = 8'($urandom_range(0, 3));
         settle_width = 4'($urandom_range(0, 4));
         seq_en = 1'($urandom_range(0, 1));
         seq = {8'($urandom), 32'($urandom)};
         fifo_threshold = 4'($urandom_range(0, 15));
         en = 1'b1;
         for (int c = 0; c < 300; c++) begin
            bus.wr = ($urandom_range(0, 2) == 0);
            bus.w_data = 12'($urandom);
            err_clr = ($urandom_range(0, 31) == 0);
            ch_sel_in = 3'($urandom);
            en = ($urandom_range(0, 63) != 0);
            rst = ($urandom_range(0, 249) == 0);
            step(1);
         end
         bus.wr = 1'b0; err_clr = 1'b0; rst = 1'b0;
      end
      en = 1'b0; step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
